// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  // RISC-V M-extension funct3 encoding
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Divide/remainder family
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is interpreted as two's complement
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is interpreted as two's complement
  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module muldiv_divstep
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] trial_c;

  // Keep the difference only when it does not borrow; quotient bit records the outcome
  always_comb begin
    trial_c = {rem, quo[WIDTH-1]} - {1'b0, divisor};
    if (trial_c[WIDTH]) begin
      rem_next = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = trial_c[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M multiply/divide unit, one bit per cycle on operand magnitudes.
// Optional divider: define MULDIV_DIVIDER_EN; otherwise divide ops return 0 via the fast path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   acc, lo, mcand;
  logic               neg_q;

  logic               accept_c, last_c, fast_c;
  logic [WIDTH-1:0]   fast_res_c;
  logic               sign_a_c, sign_b_c;
  logic [WIDTH:0]     msum_c;
  logic [WIDTH-1:0]   acc_n_c, lo_n_c, res_c;
  logic [2*WIDTH-1:0] prod_c;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  assign sign_a_c = is_signed_a(op) & operand_a[WIDTH-1];
  assign sign_b_c = is_signed_b(op) & operand_b[WIDTH-1];

`ifdef MULDIV_DIVIDER_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_rem_q;
  logic [WIDTH-1:0] drem_c, dquo_c;

  muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem      (acc),
    .quo      (lo),
    .divisor  (mcand),
    .rem_next (drem_c),
    .quo_next (dquo_c)
  );

  // Divide by zero and signed overflow resolve immediately
  always_comb begin
    fast_c     = 1'b0;
    fast_res_c = '0;
    if (is_div(op)) begin
      if (operand_b == '0) begin
        fast_c     = 1'b1;
        fast_res_c = op[1] ? operand_a : '1;
      end else if (is_signed_a(op) && operand_a == MIN_NEG && operand_b == '1) begin
        fast_c     = 1'b1;
        fast_res_c = op[1] ? '0 : operand_a;
      end
    end
  end
`else
  // Without a divider every divide op resolves immediately to zero
  always_comb begin
    fast_c     = is_div(op);
    fast_res_c = '0;
  end
`endif

  // Next-state logic; flush overrides start and CALC completion
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    last_c     = (cnt == CNT_W'(WIDTH - 1));
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          accept_c   = 1'b1;
          state_next = fast_c ? DONE : CALC;
        end
        CALC: if (last_c) state_next = DONE;
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register with registered status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next == IDLE);
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // One iteration of the active algorithm plus sign fixup of the final value
  always_comb begin
    msum_c  = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
    acc_n_c = msum_c[WIDTH:1];
    lo_n_c  = {msum_c[0], lo[WIDTH-1:1]};
    prod_c  = {acc_n_c, lo_n_c};
    if (neg_q) prod_c = -prod_c;
    res_c   = (op_q == OP_MUL) ? prod_c[WIDTH-1:0] : prod_c[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIVIDER_EN
    if (is_div(op_q)) begin
      acc_n_c = drem_c;
      lo_n_c  = dquo_c;
      if (op_q[1]) res_c = neg_rem_q ? -drem_c : drem_c;
      else         res_c = neg_q ? -dquo_c : dquo_c;
    end
`endif
  end

  // Operand capture, iteration registers and result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op_q   <= '0;
      acc    <= '0;
      lo     <= '0;
      mcand  <= '0;
      neg_q  <= 1'b0;
      result <= '0;
`ifdef MULDIV_DIVIDER_EN
      neg_rem_q <= 1'b0;
`endif
    end else if (accept_c) begin
      cnt   <= '0;
      op_q  <= op;
      acc   <= '0;
      neg_q <= sign_a_c ^ sign_b_c;
      // Divide keeps the dividend in lo; multiply keeps the multiplier there
      lo    <= is_div(op) ? mag(operand_a, sign_a_c) : mag(operand_b, sign_b_c);
      mcand <= is_div(op) ? mag(operand_b, sign_b_c) : mag(operand_a, sign_a_c);
`ifdef MULDIV_DIVIDER_EN
      neg_rem_q <= sign_a_c;
`endif
      if (fast_c) result <= fast_res_c;
    end else if (state == CALC && !flush) begin
      acc <= acc_n_c;
      lo  <= lo_n_c;
      cnt <= cnt + CNT_W'(1);
      if (last_c) result <= res_c;
    end
  end

endmodule
